// File: rtl/mdu.sv
// Iterative multiply/divide unit with the HI/LO registers.
// MULT/MULTU use a radix-2 shift-add multiplier and DIV/DIVU use restoring division.
// Both take WIDTH iteration cycles followed by one fix-up cycle. MTHI/MTLO write in one cycle.
module mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
  localparam logic [2:0] OpMthi = 3'd4;
  localparam logic [2:0] OpMtlo = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_q;   // product/quotient must be negated
  logic               rneg_q;  // remainder must be negated (dividend was negative)
  logic               dz_q;    // divide by zero

  logic               md_start;
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand decode: signed ops latch magnitudes plus sign flags.
  always_comb begin
    md_start = start && !op[2];
    // A mult/div start is honoured in idle, and also in the fix-up cycle for back-to-back issue.
    accept   = md_start && (state_q == StIdle || state_q == StFin);
    a_neg    = !op[0] && A[WIDTH-1];
    b_neg    = !op[0] && B[WIDTH-1];
    a_mag    = a_neg ? (~A + 1'b1) : A;
    b_mag    = b_neg ? (~B + 1'b1) : B;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (is_div_q) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final accumulator into HI/LO values.
  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo = dz_q ? '1 : (neg_q ? (~quo + 1'b1) : quo);
      res_hi = rneg_q ? (~rem + 1'b1) : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && op == OpMthi) hi <= A;
          if (start && op == OpMtlo) lo <= A;
        end
        StRun: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) state_q <= StFin;
        end
        StFin: begin
          hi      <= res_hi;
          lo      <= res_lo;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Accepting a new operation overrides the idle/fix-up defaults above.
      if (accept) begin
        state_q  <= StRun;
        busy     <= 1'b1;
        cnt_q    <= '0;
        is_div_q <= op[1];
        neg_q    <= a_neg ^ b_neg;
        rneg_q   <= a_neg;
        dz_q     <= op[1] && (B == '0);
        if (op[1]) begin
          acc_q  <= {{WIDTH{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end else begin
          acc_q  <= {{WIDTH{1'b0}}, b_mag};
          opnd_q <= a_mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu with hand-computed HI/LO results.
module tb_mdu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int nvec = 0;
  int nmis = 0;

  mdu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, then watch 40 cycles counting busy/done; optionally inject a second start.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output int bc, output int dn);
    bc = 0;
    dn = 0;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dn++;
      start = 1'b0;
      A = 32'hDEAD_BEEF;
      B = 32'h0BAD_F00D;
      if (k == inj) begin
        start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd7;
      end
    end
    start = 1'b0;
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [W-1:0] a);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bc, dn;
    rst_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, bc, dn);
    check("multu busy cycles", 64'(bc), 64'd33);
    check("multu done pulses", 64'(dn), 64'd1);
    check("multu hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu lo", 64'(lo), 64'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, bc, dn);
    check("mult hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo", 64'(lo), 64'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, bc, dn);
    check("div lo", 64'(lo), 64'hFFFF_FFFD);
    check("div hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(3'd3, 32'd100, 32'd0, 0, bc, dn);
    check("divu0 lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0 hi", 64'(hi), 64'd100);
    check("divu0 busy cycles", 64'(bc), 64'd33);
    check("divu0 done pulses", 64'(dn), 64'd1);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, bc, dn);
    check("divovf lo", 64'(lo), 64'h8000_0000);
    check("divovf hi", 64'(hi), 64'd0);

    mt_op(3'd4, 32'h1234_5678);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo held", 64'(lo), 64'h8000_0000);
    check("mthi busy", 64'(busy), 64'd0);
    mt_op(3'd5, 32'h9ABC_DEF0);
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi held", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("mt done", 64'(done), 64'd0);

    // 0x10000 * 0x10001 = 0x1_0001_0000; a start while busy carries 5*7
    run_op(3'd1, 32'h0001_0000, 32'h0001_0001, 10, bc, dn);
    check("busy-start busy cycles", 64'(bc), 64'd33);
    check("busy-start done pulses", 64'(dn), 64'd1);
    check("busy-start hi", 64'(hi), 64'h0000_0001);
    check("busy-start lo", 64'(lo), 64'h0001_0000);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-rst busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("midrst no activity", 64'(dn), 64'd0);

    run_op(3'd3, 32'd1000, 32'd3, 0, bc, dn);
    check("divu lo", 64'(lo), 64'd333);
    check("divu hi", 64'(hi), 64'd1);
    check("divu done pulses", 64'(dn), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
